// File: rtl/id_ex_pipeline_stage_if.sv
// ID/EX stage bus: decoder/register-file side in, EX side and hazard status out.
// master drives the ID fields and EX controls; slave is the pipeline register.
interface id_ex_pipeline_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  id_valid;
  logic                  id_RegDst, id_BranchEQ, id_BranchNE, id_MemRead;
  logic                  id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic [2:0]            id_ALUOp;
  logic [DATA_WIDTH-1:0] id_ReadData1, id_ReadData2, id_Imm, id_PC4;
  logic [REG_ADDR_W-1:0] id_Rs, id_Rt, id_Rd;
  logic                  ex_flush, ex_hold;

  logic                  stall;
  logic                  ex_valid;
  logic                  ex_RegDst, ex_BranchEQ, ex_BranchNE, ex_MemRead;
  logic                  ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [2:0]            ex_ALUOp;
  logic [DATA_WIDTH-1:0] ex_ReadData1, ex_ReadData2, ex_Imm, ex_PC4;
  logic [REG_ADDR_W-1:0] ex_Rs, ex_Rt, ex_Rd;
  logic [CNT_WIDTH-1:0]  stall_count, flush_count;

  modport master (
    output id_valid, id_RegDst, id_BranchEQ, id_BranchNE, id_MemRead,
           id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp,
           id_ReadData1, id_ReadData2, id_Imm, id_PC4, id_Rs, id_Rt, id_Rd,
           ex_flush, ex_hold,
    input  stall, ex_valid, ex_RegDst, ex_BranchEQ, ex_BranchNE, ex_MemRead,
           ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp,
           ex_ReadData1, ex_ReadData2, ex_Imm, ex_PC4, ex_Rs, ex_Rt, ex_Rd,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_RegDst, id_BranchEQ, id_BranchNE, id_MemRead,
           id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp,
           id_ReadData1, id_ReadData2, id_Imm, id_PC4, id_Rs, id_Rt, id_Rd,
           ex_flush, ex_hold,
    output stall, ex_valid, ex_RegDst, ex_BranchEQ, ex_BranchNE, ex_MemRead,
           ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp,
           ex_ReadData1, ex_ReadData2, ex_Imm, ex_PC4, ex_Rs, ex_Rt, ex_Rd,
           stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_pipeline_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection
// on stall/flush, and saturating stall/flush event counters.
module id_ex_pipeline_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic reset,
  id_ex_pipeline_stage_if.slave io_bus
);
  typedef struct packed {
    logic       RegDst, BranchEQ, BranchNE, MemRead;
    logic       MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [2:0] ALUOp;
  } ctrl_t;

  ctrl_t                 w_id_ctrl, r_ctrl;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rd1, r_rd2, r_imm, r_pc4;
  logic [REG_ADDR_W-1:0] r_rs, r_rt, r_rd;
  logic [CNT_WIDTH-1:0]  r_stall_cnt, r_flush_cnt;
  logic                  w_use_rt, w_load_use, w_stall;

  assign w_id_ctrl = {io_bus.id_RegDst, io_bus.id_BranchEQ, io_bus.id_BranchNE,
                      io_bus.id_MemRead, io_bus.id_MemtoReg, io_bus.id_MemWrite,
                      io_bus.id_ALUSrc, io_bus.id_RegWrite, io_bus.id_ALUOp};

  // rs is always read; rt only when it is an ALU source or store data
  assign w_use_rt   = ~io_bus.id_ALUSrc | io_bus.id_MemWrite;
  assign w_load_use = io_bus.id_valid & r_valid & r_ctrl.MemRead & (r_rt != '0) &
                      ((r_rt == io_bus.id_Rs) | (w_use_rt & (r_rt == io_bus.id_Rt)));
  assign w_stall    = w_load_use & ~io_bus.ex_flush & ~io_bus.ex_hold & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_pc4       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!io_bus.ex_hold) begin
      if (io_bus.ex_flush || w_load_use) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_rd1   <= '0;
        r_rd2   <= '0;
        r_imm   <= '0;
        r_pc4   <= '0;
        r_rs    <= '0;
        r_rt    <= '0;
        r_rd    <= '0;
        // flush outranks load-use, so only one counter moves per edge
        if (io_bus.ex_flush) begin
          if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
        end else begin
          if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
      end else begin
        r_valid <= io_bus.id_valid;
        r_ctrl  <= io_bus.id_valid ? w_id_ctrl : '0;
        r_rd1   <= io_bus.id_ReadData1;
        r_rd2   <= io_bus.id_ReadData2;
        r_imm   <= io_bus.id_Imm;
        r_pc4   <= io_bus.id_PC4;
        r_rs    <= io_bus.id_Rs;
        r_rt    <= io_bus.id_Rt;
        r_rd    <= io_bus.id_Rd;
      end
    end
  end

  assign io_bus.stall        = w_stall;
  assign io_bus.ex_valid     = r_valid;
  assign io_bus.ex_RegDst    = r_ctrl.RegDst;
  assign io_bus.ex_BranchEQ  = r_ctrl.BranchEQ;
  assign io_bus.ex_BranchNE  = r_ctrl.BranchNE;
  assign io_bus.ex_MemRead   = r_ctrl.MemRead;
  assign io_bus.ex_MemtoReg  = r_ctrl.MemtoReg;
  assign io_bus.ex_MemWrite  = r_ctrl.MemWrite;
  assign io_bus.ex_ALUSrc    = r_ctrl.ALUSrc;
  assign io_bus.ex_RegWrite  = r_ctrl.RegWrite;
  assign io_bus.ex_ALUOp     = r_ctrl.ALUOp;
  assign io_bus.ex_ReadData1 = r_rd1;
  assign io_bus.ex_ReadData2 = r_rd2;
  assign io_bus.ex_Imm       = r_imm;
  assign io_bus.ex_PC4       = r_pc4;
  assign io_bus.ex_Rs        = r_rs;
  assign io_bus.ex_Rt        = r_rt;
  assign io_bus.ex_Rd        = r_rd;
  assign io_bus.stall_count  = r_stall_cnt;
  assign io_bus.flush_count  = r_flush_cnt;
endmodule

// File: tb/tb_id_ex_pipeline_stage.sv
// Bench for id_ex_pipeline_stage: directed hazard scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_id_ex_pipeline_stage;
  localparam int DW   = 32;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          valid;
    logic          RegDst, BranchEQ, BranchNE, MemRead;
    logic          MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [2:0]    ALUOp;
    logic [DW-1:0] rd1, rd2, imm, pc4;
    logic [RW-1:0] rs, rt, rd;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_pipeline_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .CNT_WIDTH(CW)) bus();
  id_ex_pipeline_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .io_bus(bus));

  int     tests = 0, fails = 0;
  instr_t mdl_ex;
  int     mdl_sc, mdl_fc;
  bit     mdl_ok = 0;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic instr_t get_ex();
    instr_t e;
    e = {bus.ex_valid, bus.ex_RegDst, bus.ex_BranchEQ, bus.ex_BranchNE, bus.ex_MemRead,
         bus.ex_MemtoReg, bus.ex_MemWrite, bus.ex_ALUSrc, bus.ex_RegWrite, bus.ex_ALUOp,
         bus.ex_ReadData1, bus.ex_ReadData2, bus.ex_Imm, bus.ex_PC4,
         bus.ex_Rs, bus.ex_Rt, bus.ex_Rd};
    return e;
  endfunction

  // Model: does the instruction in ID read the register a load in EX is fetching?
  function automatic bit mdl_load_use(input instr_t x);
    bit reads_rt;
    reads_rt = !x.ALUSrc || x.MemWrite;
    return x.valid && mdl_ex.valid && mdl_ex.MemRead && mdl_ex.rt != 0 &&
           (mdl_ex.rt == x.rs || (reads_rt && mdl_ex.rt == x.rt));
  endfunction

  function automatic void mdl_edge(input instr_t x, input bit fl, hd, rs);
    bit lu;
    lu = mdl_load_use(x);
    if (rs) begin
      mdl_ex = '0; mdl_sc = 0; mdl_fc = 0;
    end else if (hd) begin
    end else if (fl) begin
      mdl_ex = '0; mdl_fc = (mdl_fc < CMAX) ? mdl_fc + 1 : CMAX;
    end else if (lu) begin
      mdl_ex = '0; mdl_sc = (mdl_sc < CMAX) ? mdl_sc + 1 : CMAX;
    end else begin
      mdl_ex = x;
      if (!x.valid) begin
        mdl_ex.RegDst = 0; mdl_ex.BranchEQ = 0; mdl_ex.BranchNE = 0; mdl_ex.MemRead = 0;
        mdl_ex.MemtoReg = 0; mdl_ex.MemWrite = 0; mdl_ex.ALUSrc = 0; mdl_ex.RegWrite = 0;
        mdl_ex.ALUOp = 3'd0;
      end
    end
  endfunction

  // One clock: drive after negedge, compare everything, update model at posedge.
  task automatic cyc(input instr_t x, input bit fl, hd, rs, output bit st);
    bit exp_st;
    reset = rs; bus.ex_flush = fl; bus.ex_hold = hd;
    bus.id_valid = x.valid; bus.id_RegDst = x.RegDst; bus.id_BranchEQ = x.BranchEQ;
    bus.id_BranchNE = x.BranchNE; bus.id_MemRead = x.MemRead; bus.id_MemtoReg = x.MemtoReg;
    bus.id_MemWrite = x.MemWrite; bus.id_ALUSrc = x.ALUSrc; bus.id_RegWrite = x.RegWrite;
    bus.id_ALUOp = x.ALUOp; bus.id_ReadData1 = x.rd1; bus.id_ReadData2 = x.rd2;
    bus.id_Imm = x.imm; bus.id_PC4 = x.pc4; bus.id_Rs = x.rs; bus.id_Rt = x.rt; bus.id_Rd = x.rd;
    #1;
    st = bus.stall;
    if (mdl_ok) begin
      exp_st = mdl_load_use(x) && !fl && !hd && !rs;
      chk("stall", 160'(st), 160'(exp_st));
      chk("ex_regs", 160'(get_ex()), 160'(mdl_ex));
      chk("stall_count", 160'(bus.stall_count), 160'(mdl_sc));
      chk("flush_count", 160'(bus.flush_count), 160'(mdl_fc));
    end
    @(posedge clk);
    mdl_edge(x, fl, hd, rs);
    if (rs) mdl_ok = 1;
    @(negedge clk);
  endtask

  function automatic instr_t lw(input int rt, input int rs);
    instr_t x = '0;
    x.valid = 1; x.MemRead = 1; x.MemtoReg = 1; x.ALUSrc = 1; x.RegWrite = 1;
    x.rt = RW'(rt); x.rs = RW'(rs); x.imm = 32'h10; x.pc4 = 32'h400;
    return x;
  endfunction

  function automatic instr_t add(input int rd, input int rs, input int rt);
    instr_t x = '0;
    x.valid = 1; x.RegDst = 1; x.RegWrite = 1; x.ALUOp = 3'b010;
    x.rd = RW'(rd); x.rs = RW'(rs); x.rt = RW'(rt);
    x.rd1 = 32'h1111; x.rd2 = 32'h2222; x.pc4 = 32'h404;
    return x;
  endfunction

  function automatic int pick_reg();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 8;
      2: return 9;
      3: return 10;
      default: return 11;
    endcase
  endfunction

  function automatic instr_t rnd_instr();
    instr_t x;
    x.valid = ($urandom_range(0, 7) != 0);
    x.RegDst = 1'($urandom); x.BranchEQ = 1'($urandom); x.BranchNE = 1'($urandom);
    x.MemRead = ($urandom_range(0, 2) == 0); x.MemtoReg = 1'($urandom);
    x.MemWrite = 1'($urandom); x.ALUSrc = 1'($urandom); x.RegWrite = 1'($urandom);
    x.ALUOp = 3'($urandom);
    x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom; x.pc4 = $urandom;
    x.rs = RW'(pick_reg()); x.rt = RW'(pick_reg()); x.rd = RW'(pick_reg());
    return x;
  endfunction

  instr_t nop = '0;
  instr_t cur, sw_i, addi_i;
  bit     st, keep;

  initial begin
    reset = 1'b1;
    @(negedge clk);
    cyc(nop, 0, 0, 1, st);

    // reset with a valid load captured
    cyc(lw(8, 9), 0, 0, 0, st);
    chk("lw_captured", 160'(bus.ex_MemRead), 160'(1));
    cyc(add(9, 8, 10), 0, 0, 1, st);
    chk("stall_in_reset", 160'(st), 160'(0));
    chk("reset_ex", 160'(get_ex()), 160'(0));
    chk("reset_cnt", 160'({bus.stall_count, bus.flush_count}), 160'(0));

    // LW $t0 ; ADD $t1,$t0,$t2
    cyc(lw(8, 9), 0, 0, 0, st);
    cyc(add(9, 8, 10), 0, 0, 0, st);
    chk("lu_stall", 160'(st), 160'(1));
    chk("lu_bubble", 160'({bus.ex_valid, bus.ex_RegWrite, bus.ex_MemRead}), 160'(0));
    cyc(add(9, 8, 10), 0, 0, 0, st);
    chk("lu_one_cycle", 160'(st), 160'(0));
    chk("lu_add_in_ex", 160'({bus.ex_valid, bus.ex_Rs, bus.ex_Rd}), 160'({1'b1, 5'd8, 5'd9}));
    chk("lu_stall_count", 160'(bus.stall_count), 160'(1));

    // ADDI reads only rs, so a matching rt is harmless
    cyc(lw(8, 9), 0, 0, 0, st);
    addi_i = '0; addi_i.valid = 1; addi_i.ALUSrc = 1; addi_i.RegWrite = 1;
    addi_i.rs = 11; addi_i.rt = 8; addi_i.imm = 5;
    cyc(addi_i, 0, 0, 0, st);
    chk("addi_no_stall", 160'(st), 160'(0));
    // SW reads rt as store data
    cyc(lw(8, 9), 0, 0, 0, st);
    sw_i = '0; sw_i.valid = 1; sw_i.ALUSrc = 1; sw_i.MemWrite = 1; sw_i.rs = 11; sw_i.rt = 8;
    cyc(sw_i, 0, 0, 0, st);
    chk("sw_stall", 160'(st), 160'(1));
    cyc(sw_i, 0, 0, 0, st);

    // $zero never creates a hazard
    cyc(lw(0, 9), 0, 0, 0, st);
    cyc(add(9, 0, 0), 0, 0, 0, st);
    chk("zero_no_stall", 160'(st), 160'(0));

    // flush wins over load-use
    cyc(nop, 0, 0, 1, st);
    cyc(lw(8, 9), 0, 0, 0, st);
    cyc(add(9, 8, 10), 1, 0, 0, st);
    chk("flush_no_stall", 160'(st), 160'(0));
    chk("flush_bubble", 160'(bus.ex_valid), 160'(0));
    chk("flush_counts", 160'({bus.flush_count, bus.stall_count}), 160'({4'd1, 4'd0}));

    // hold freezes EX with a load-use pending
    cyc(nop, 0, 0, 1, st);
    cyc(lw(8, 9), 0, 0, 0, st);
    for (int i = 0; i < 3; i++) begin
      cyc(add(9, 8, 10), 0, 1, 0, st);
      chk("hold_no_stall", 160'(st), 160'(0));
      chk("hold_frozen", 160'({bus.ex_MemRead, bus.ex_Rt, bus.stall_count}), 160'({1'b1, 5'd8, 4'd0}));
    end
    cyc(add(9, 8, 10), 0, 0, 0, st);
    chk("hold_release_stall", 160'(st), 160'(1));

    // stall counter saturation
    cyc(nop, 0, 0, 1, st);
    for (int i = 0; i < CMAX + 5; i++) begin
      cyc(lw(8, 9), 0, 0, 0, st);
      cyc(add(9, 8, 10), 0, 0, 0, st);
      cyc(add(9, 8, 10), 0, 0, 0, st);
    end
    chk("stall_sat", 160'(bus.stall_count), 160'(CMAX));

    // random traffic; ID is re-presented while stalled or held
    keep = 0;
    cur = nop;
    for (int i = 0; i < 1500; i++) begin
      bit fl, hd, rs;
      if (!keep) cur = rnd_instr();
      fl = ($urandom_range(0, 9) == 0);
      hd = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cyc(cur, fl, hd, rs, st);
      keep = st || hd;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
